// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back value, owns the register file with write-through
// read ports, latches halt, and keeps cycle/retired-instruction counters.
module wb_stage #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause,
   input  logic             valid,
   input  logic             MemToReg,
   input  logic             jal,
   input  logic             halt,
   input  logic             RegWrite,
   input  logic [AW-1:0]    RW,
   input  logic [DW-1:0]    p,
   input  logic [DW-1:0]    R,
   input  logic [DW-1:0]    D,
   input  logic [AW-1:0]    RA,
   input  logic [AW-1:0]    RB,
   output logic [DW-1:0]    A,
   output logic [DW-1:0]    B,
   output logic [DW-1:0]    wb_data,
   output logic             wb_we,
   output logic [AW-1:0]    wb_rw,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   input  logic [AW-1:0]    dbg_addr,
   output logic [DW-1:0]    dbg_data
);

   localparam int NREG = 1 << AW;

   logic [DW-1:0]    r_rf [NREG];
   logic             r_pause_q;
   logic             r_halted;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_retire_cnt;
   logic             w_live;

   // Register 0 is hard-wired to zero; a same-cycle write bypasses the array.
   function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] addr,
                                             input logic          we,
                                             input logic [AW-1:0] waddr,
                                             input logic [DW-1:0] wdata,
                                             input logic [DW-1:0] rfval);
      if (addr == '0)
         return '0;
      else if (we && (addr == waddr))
         return wdata;
      else
         return rfval;
   endfunction

   always_comb begin
      wb_data = jal ? p : (MemToReg ? D : R);
      // A held MEM/WB slot (paused last edge) repeats an instruction already retired.
      w_live  = valid & ~r_pause_q & ~r_halted;
      wb_we   = w_live & RegWrite & (RW != '0);
      wb_rw   = RW;
   end

   always_comb begin
      A        = rd_port(RA,       wb_we, RW, wb_data, r_rf[RA]);
      B        = rd_port(RB,       wb_we, RW, wb_data, r_rf[RB]);
      dbg_data = rd_port(dbg_addr, wb_we, RW, wb_data, r_rf[dbg_addr]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            r_rf[i] <= '0;
         r_pause_q    <= 1'b0;
         r_halted     <= 1'b0;
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_pause_q <= pause;
         if (wb_we)
            r_rf[RW] <= wb_data;
         if (!r_halted)
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (w_live)
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
         if (w_live && halt)
            r_halted <= 1'b1;
      end
   end

   assign halted     = r_halted;
   assign cycle_cnt  = r_cycle_cnt;
   assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized instruction stream against an
// instruction-level reference model (one retirement per issued instruction, however long it is held).
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, pause, valid, MemToReg, jal, halt, RegWrite;
   logic [4:0]  RW, RA, RB, dbg_addr, wb_rw;
   logic [31:0] p, R, D, A, B, wb_data, dbg_data, cycle_cnt, retire_cnt;
   logic        wb_we, halted;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_rf [32];
   logic        m_halted;
   logic [31:0] m_cyc, m_ret;

   wb_stage dut (
      .clk(clk), .rst(rst), .pause(pause), .valid(valid), .MemToReg(MemToReg),
      .jal(jal), .halt(halt), .RegWrite(RegWrite), .RW(RW), .p(p), .R(R), .D(D),
      .RA(RA), .RB(RB), .A(A), .B(B), .wb_data(wb_data), .wb_we(wb_we),
      .wb_rw(wb_rw), .halted(halted), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_wbd();
      if (jal) return p;
      return MemToReg ? D : R;
   endfunction

   // first = this cycle is the instruction's first appearance in MEM/WB
   function automatic logic exp_we(input bit first);
      return valid && first && !m_halted && RegWrite && (RW != 5'd0);
   endfunction

   function automatic logic [31:0] exp_port(input logic [4:0] addr, input bit first);
      if (addr == 5'd0) return 32'd0;
      if (exp_we(first) && addr == RW) return exp_wbd();
      return m_rf[addr];
   endfunction

   // Applies the architectural effect of the cycle's inputs to the model.
   task automatic model_edge(input bit first);
      bit live;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
         m_halted = 1'b0; m_cyc = 0; m_ret = 0;
      end else begin
         live = valid && first && !m_halted;
         if (live && RegWrite && RW != 5'd0) m_rf[RW] = exp_wbd();
         if (!m_halted) m_cyc = m_cyc + 1;
         if (live) m_ret = m_ret + 1;
         if (live && halt) m_halted = 1'b1;
      end
   endtask

   task automatic step(input bit first);
      model_edge(first);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic m2r, input logic j, input logic h,
                        input logic we, input logic [4:0] rw, input logic [31:0] pp,
                        input logic [31:0] r, input logic [31:0] d);
      valid = v; MemToReg = m2r; jal = j; halt = h; RegWrite = we;
      RW = rw; p = pp; R = r; D = d;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1; pause = 1'b0; bubble();
      step(1'b1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      do_reset();
      RA = 5'd3; RB = 5'd31; dbg_addr = 5'd17;
      #1;
      checks++; if (A !== 32'd0) begin errors++; $display("FAIL reset_A got %h want 0", A); end
      checks++; if (B !== 32'd0) begin errors++; $display("FAIL reset_B got %h want 0", B); end
      checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_dbg got %h want 0", dbg_data); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
      checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cyc got %0d want 0", cycle_cnt); end
      checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_ret got %0d want 0", retire_cnt); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_we); end
   endtask

   task automatic test_write_through();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1234, 32'd0);
      RA = 5'd5; RB = 5'd6; dbg_addr = 5'd5;
      #1;
      checks++; if (A !== 32'h1234) begin errors++; $display("FAIL wt_A got %h want 1234", A); end
      checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL wt_dbg got %h want 1234", dbg_data); end
      checks++; if (B !== 32'd0) begin errors++; $display("FAIL wt_B got %h want 0", B); end
      checks++; if (wb_we !== 1'b1 || wb_rw !== 5'd5) begin errors++; $display("FAIL wt_we got %b/%0d want 1/5", wb_we, wb_rw); end
      step(1'b1);
      bubble();
      #1;
      checks++; if (A !== 32'h1234) begin errors++; $display("FAIL wt_rf5 got %h want 1234", A); end
      checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL wt_ret got %0d want 1", retire_cnt); end
      step(1'b1);
   endtask

   task automatic test_mux();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'h1, 32'hCAFE);
      #1;
      checks++; if (wb_data !== 32'hCAFE) begin errors++; $display("FAIL mux_mem got %h want cafe", wb_data); end
      step(1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 32'h0040_0008, 32'h1, 32'hCAFE);
      #1;
      checks++; if (wb_data !== 32'h0040_0008) begin errors++; $display("FAIL mux_jal got %h want 00400008", wb_data); end
      step(1'b1);
      bubble(); RA = 5'd7; RB = 5'd31;
      #1;
      checks++; if (A !== 32'hCAFE) begin errors++; $display("FAIL mux_rf7 got %h want cafe", A); end
      checks++; if (B !== 32'h0040_0008) begin errors++; $display("FAIL mux_rf31 got %h want 00400008", B); end
      step(1'b1);
   endtask

   task automatic test_rw0();
      logic [31:0] ret0;
      ret0 = retire_cnt;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
      RA = 5'd0;
      #1;
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rw0_we got %b want 0", wb_we); end
      checks++; if (A !== 32'd0) begin errors++; $display("FAIL rw0_A got %h want 0", A); end
      step(1'b1);
      bubble();
      #1;
      checks++; if (A !== 32'd0) begin errors++; $display("FAIL rw0_A_after got %h want 0", A); end
      checks++; if (retire_cnt !== ret0 + 1) begin errors++; $display("FAIL rw0_ret got %0d want %0d", retire_cnt, ret0 + 1); end
   endtask

   task automatic test_pause();
      logic [31:0] ret0, cyc0;
      ret0 = retire_cnt; cyc0 = cycle_cnt;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 32'h0BAD_F00D, 32'd0);
      RA = 5'd9;
      for (int j = 0; j < 4; j++) begin
         pause = (j < 3);
         #1;
         checks++;
         if (wb_we !== (j == 0)) begin errors++; $display("FAIL pause_we[%0d] got %b want %b", j, wb_we, (j == 0)); end
         step(j == 0);
         checks++;
         if (retire_cnt !== ret0 + 1) begin errors++; $display("FAIL pause_ret[%0d] got %0d want %0d", j, retire_cnt, ret0 + 1); end
      end
      pause = 1'b0; bubble();
      #1;
      checks++; if (cycle_cnt !== cyc0 + 4) begin errors++; $display("FAIL pause_cyc got %0d want %0d", cycle_cnt, cyc0 + 4); end
      checks++; if (A !== 32'h0BAD_F00D) begin errors++; $display("FAIL pause_rf9 got %h want 0badf00d", A); end
   endtask

   task automatic test_halt();
      do_reset();
      for (int c = 0; c < 9; c++) step(1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'd0, 32'h0000_ABCD, 32'd0);
      step(1'b1);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
      checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL halt_cyc got %0d want 10", cycle_cnt); end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'h5555_5555, 32'd0);
      RA = 5'd4; dbg_addr = 5'd4;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL halt_we got %b want 0", wb_we); end
         checks++; if (A !== 32'h0000_ABCD) begin errors++; $display("FAIL halt_A got %h want abcd", A); end
         step(1'b1);
      end
      checks++; if (dbg_data !== 32'h0000_ABCD) begin errors++; $display("FAIL halt_rf4 got %h want abcd", dbg_data); end
      checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL halt_cyc_frozen got %0d want 10", cycle_cnt); end
      checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL halt_ret_frozen got %0d want 1", retire_cnt); end
   endtask

   task automatic test_rst_override();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'h99, 32'd0);
      step(1'b1);
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'd0, 32'h77, 32'd0);
      step(1'b1);
      rst = 1'b0; bubble(); dbg_addr = 5'd3; RA = 5'd3;
      #1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rstov_halted got %b want 0", halted); end
      checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL rstov_rf3 got %h want 0", dbg_data); end
      checks++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
         errors++; $display("FAIL rstov_cnt got %0d/%0d want 0/0", cycle_cnt, retire_cnt); end
   endtask

   task automatic test_random();
      int h;
      do_reset();
      for (int n = 0; n < 200; n++) begin
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0),
               (n > 150) && ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
         h = $urandom_range(0, 2);
         for (int j = 0; j <= h; j++) begin
            pause = (j < h);
            RA = 5'($urandom_range(0, 31)); RB = 5'($urandom_range(0, 31));
            dbg_addr = (j == 0) ? RW : 5'($urandom_range(0, 31));
            #1;
            checks++; if (wb_data !== exp_wbd()) begin errors++; $display("FAIL rnd_wbd got %h want %h", wb_data, exp_wbd()); end
            checks++; if (wb_we !== exp_we(j == 0)) begin errors++; $display("FAIL rnd_we got %b want %b", wb_we, exp_we(j == 0)); end
            checks++; if (A !== exp_port(RA, j == 0)) begin errors++; $display("FAIL rnd_A got %h want %h", A, exp_port(RA, j == 0)); end
            checks++; if (B !== exp_port(RB, j == 0)) begin errors++; $display("FAIL rnd_B got %h want %h", B, exp_port(RB, j == 0)); end
            checks++; if (dbg_data !== exp_port(dbg_addr, j == 0)) begin
               errors++; $display("FAIL rnd_dbg got %h want %h", dbg_data, exp_port(dbg_addr, j == 0)); end
            step(j == 0);
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted got %b want %b", halted, m_halted); end
            checks++; if (cycle_cnt !== m_cyc) begin errors++; $display("FAIL rnd_cyc got %0d want %0d", cycle_cnt, m_cyc); end
            checks++; if (retire_cnt !== m_ret) begin errors++; $display("FAIL rnd_ret got %0d want %0d", retire_cnt, m_ret); end
         end
      end
      pause = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pause = 1'b0; RA = 5'd0; RB = 5'd0; dbg_addr = 5'd0;
      bubble();
      m_halted = 1'b0; m_cyc = 0; m_ret = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      @(negedge clk);
      test_reset();
      test_write_through();
      test_mux();
      test_rw0();
      test_pause();
      test_halt();
      test_rst_override();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
